// File: rtl/demux1_16_12bit_reg.sv
// Registered 1:16 demultiplexer: each accepted word lands in one lane register,
// chosen by sel or by an auto-increment pointer, with per-lane valid flags and frame tracking.

module demux1_16_12bit_lane #(
  parameter int LARGURA = 12
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               we,
  input  logic               clr,
  input  logic [LARGURA-1:0] dado,
  output logic [LARGURA-1:0] q,
  output logic               v
);
  // clr only drops the flag; lane data survives a frame clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
      v <= 1'b0;
    end else if (clr) begin
      v <= 1'b0;
    end else if (we) begin
      q <= dado;
      v <= 1'b1;
    end
  end
endmodule

module demux1_16_12bit_reg #(
  parameter int LARGURA  = 12,
  parameter int N_SAIDAS = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        escreve,
  input  logic                        auto,
  input  logic [3:0]                  sel,
  input  logic [LARGURA-1:0]          dado,
  input  logic                        limpa,
  output logic [N_SAIDAS*LARGURA-1:0] saida,
  output logic [N_SAIDAS-1:0]         valido,
  output logic [3:0]                  ponteiro,
  output logic                        quadro_pronto,
  output logic [1:0]                  estado
);
  typedef enum logic [1:0] {
    OCIOSO      = 2'b00,
    PREENCHENDO = 2'b01,
    COMPLETO    = 2'b10
  } estado_t;

  localparam logic [N_SAIDAS-1:0] TODOS = {N_SAIDAS{1'b1}};

  estado_t             st;
  logic [3:0]          alvo;
  logic                aceita;
  logic [N_SAIDAS-1:0] lane_we;
  logic [N_SAIDAS-1:0] valido_prox;
  logic                enche;

  assign alvo   = auto ? ponteiro : sel;
  assign aceita = escreve & ~limpa;

  genvar i;
  generate
    for (i = 0; i < N_SAIDAS; i++) begin : g_lane
      assign lane_we[i] = aceita && (alvo == 4'(i));
      demux1_16_12bit_lane #(.LARGURA(LARGURA)) u_lane (
        .clock (clock),
        .reset (reset),
        .we    (lane_we[i]),
        .clr   (limpa),
        .dado  (dado),
        .q     (saida[i*LARGURA +: LARGURA]),
        .v     (valido[i])
      );
    end
  endgenerate

  // Frame completes only on the not-all -> all edge, so rewrites in COMPLETO stay silent
  assign valido_prox = valido | lane_we;
  assign enche       = aceita && (valido != TODOS) && (valido_prox == TODOS);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ponteiro      <= '0;
      quadro_pronto <= 1'b0;
      st            <= OCIOSO;
    end else if (limpa) begin
      ponteiro      <= '0;
      quadro_pronto <= 1'b0;
      st            <= OCIOSO;
    end else begin
      quadro_pronto <= enche;
      if (escreve && auto)
        ponteiro <= ponteiro + 4'd1;
      case (st)
        OCIOSO:      if (aceita) st <= enche ? COMPLETO : PREENCHENDO;
        PREENCHENDO: if (enche)  st <= COMPLETO;
        COMPLETO:    st <= COMPLETO;
        default:     st <= OCIOSO;
      endcase
    end
  end

  assign estado = st;
endmodule

// File: tb/tb_demux1_16_12bit_reg.sv
// Directed bench for demux1_16_12bit_reg against a hand-maintained lane model.

module tb_demux1_16_12bit_reg;
  localparam int W = 12;
  localparam int N = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             escreve;
  logic             auto;
  logic [3:0]       sel;
  logic [W-1:0]     dado;
  logic             limpa;
  logic [N*W-1:0]   saida;
  logic [N-1:0]     valido;
  logic [3:0]       ponteiro;
  logic             quadro_pronto;
  logic [1:0]       estado;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] mdl [N];
  int pulses;

  demux1_16_12bit_reg dut (
    .clock         (clock),
    .reset         (reset),
    .escreve       (escreve),
    .auto          (auto),
    .sel           (sel),
    .dado          (dado),
    .limpa         (limpa),
    .saida         (saida),
    .valido        (valido),
    .ponteiro      (ponteiro),
    .quadro_pronto (quadro_pronto),
    .estado        (estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [N*W-1:0] packed_mdl();
    logic [N*W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k*W +: W] = mdl[k];
    return r;
  endfunction

  initial begin
    for (int k = 0; k < N; k++) mdl[k] = '0;
    reset = 1'b1; escreve = 1'b1; auto = 1'b1; sel = 4'd0; dado = 12'hABC; limpa = 1'b0;

    // 1: reset holds everything at zero even with a write strobe
    tick(); tick();
    chk("rst_saida", saida, '0);
    chk("rst_valido", {176'd0, valido}, '0);
    chk("rst_ptr", {188'd0, ponteiro}, '0);
    chk("rst_qp", {191'd0, quadro_pronto}, '0);
    chk("rst_estado", {190'd0, estado}, '0);
    escreve = 1'b0;
    reset = 1'b0;
    tick();

    // 2: auto fill of 16 lanes
    for (int k = 0; k < N; k++) begin
      auto = 1'b1; escreve = 1'b1; dado = 12'h100 + 12'(k);
      mdl[k] = 12'h100 + 12'(k);
      tick();
      if (k == 0) begin
        chk("fill_first_estado", {190'd0, estado}, 192'd1);
        chk("fill_first_ptr", {188'd0, ponteiro}, 192'd1);
      end
      if (k == 14) chk("fill_15_qp", {191'd0, quadro_pronto}, '0);
    end
    escreve = 1'b0;
    chk("fill_qp", {191'd0, quadro_pronto}, 192'd1);
    chk("fill_estado", {190'd0, estado}, 192'd2);
    chk("fill_ptr_wrap", {188'd0, ponteiro}, '0);
    chk("fill_valido", {176'd0, valido}, 192'h0FFFF);
    chk("fill_saida", saida, packed_mdl());
    tick();
    chk("fill_qp_1cyc", {191'd0, quadro_pronto}, '0);
    chk("fill_estado_hold", {190'd0, estado}, 192'd2);

    // 5: rewrite in COMPLETO
    auto = 1'b0; sel = 4'd2; dado = 12'hFFF; escreve = 1'b1; mdl[2] = 12'hFFF;
    tick();
    escreve = 1'b0;
    chk("rew_saida", saida, packed_mdl());
    chk("rew_qp", {191'd0, quadro_pronto}, '0);
    chk("rew_estado", {190'd0, estado}, 192'd2);
    chk("rew_ptr", {188'd0, ponteiro}, '0);
    tick();
    chk("rew_qp_late", {191'd0, quadro_pronto}, '0);

    // 4: limpa beats a simultaneous write
    limpa = 1'b1; escreve = 1'b1; sel = 4'd3; dado = 12'h055;
    tick();
    limpa = 1'b0; escreve = 1'b0;
    chk("col_saida", saida, packed_mdl());
    chk("col_valido", {176'd0, valido}, '0);
    chk("col_ptr", {188'd0, ponteiro}, '0);
    chk("col_estado", {190'd0, estado}, '0);

    // 3: explicit select to lane 15
    auto = 1'b0; sel = 4'hF; dado = 12'h7FF; escreve = 1'b1; mdl[15] = 12'h7FF;
    tick();
    escreve = 1'b0;
    chk("exp_saida", saida, packed_mdl());
    chk("exp_valido", {176'd0, valido}, 192'h08000);
    chk("exp_ptr", {188'd0, ponteiro}, '0);
    chk("exp_estado", {190'd0, estado}, 192'd1);

    // mode switching: pointer advances only on auto writes
    auto = 1'b1; dado = 12'h011; escreve = 1'b1; mdl[0] = 12'h011;
    tick();
    auto = 1'b0; sel = 4'd5; dado = 12'h022; mdl[5] = 12'h022;
    tick();
    escreve = 1'b0;
    chk("mode_saida", saida, packed_mdl());
    chk("mode_valido", {176'd0, valido}, 192'h08021);
    chk("mode_ptr", {188'd0, ponteiro}, 192'd1);

    // 6: async reset mid-frame, then refill
    limpa = 1'b1; tick(); limpa = 1'b0;
    pulses = 0;
    auto = 1'b1; escreve = 1'b1;
    for (int k = 0; k < 9; k++) begin
      dado = 12'h200 + 12'(k);
      tick();
      if (quadro_pronto) pulses++;
    end
    escreve = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_saida", saida, '0);
    chk("arst_valido", {176'd0, valido}, '0);
    chk("arst_ptr", {188'd0, ponteiro}, '0);
    chk("arst_estado", {190'd0, estado}, '0);
    #1 reset = 1'b0;
    for (int k = 0; k < N; k++) mdl[k] = '0;
    tick();
    escreve = 1'b1; auto = 1'b1;
    for (int k = 0; k < N; k++) begin
      dado = 12'h300 + 12'(k);
      mdl[k] = 12'h300 + 12'(k);
      tick();
      if (quadro_pronto) pulses++;
    end
    escreve = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (quadro_pronto) pulses++;
    end
    chk("refill_pulses", 192'(pulses), 192'd1);
    chk("refill_saida", saida, packed_mdl());
    chk("refill_estado", {190'd0, estado}, 192'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
